accumulate_block_pipe3: RTL and testbench

Pipe stage 3 of the k-means datapath, and the consumer of the classify stage's result. Each cycle it takes one classified point: a 4-bit centroid index (1..8) and a 91-bit packed point of 7 × 13-bit unsigned coordinates. It adds the point's coordinates into that centroid's per-coordinate sum and increments the centroid's member count. On request it streams all 8 (sum, count) records out over a valid/ready handshake to the centroid-update logic, then returns to accumulating.

---
 rtl/accumulate_block_pipe3.sv | 168 ++++++++++++++++
 tb/tb_accumulate_block_pipe3.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/accumulate_block_pipe3.sv
// k-means pipe stage 3: saturating per-centroid coordinate sums and member counts,
// streamed out as 8 (sum, count) records over a valid/ready handshake on request.
module accumulate_block_pipe3 #(
    parameter int unsigned DataWidth      = 91,
    parameter int unsigned CentroidNum    = 8,
    parameter int unsigned CordWidth      = 13,
    parameter int unsigned AccumCordWidth = 22,
    parameter int unsigned AccumWidth     = 154,
    parameter int unsigned CountWidth     = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic                  point_valid,
    input  logic [3:0]            index,
    input  logic [DataWidth-1:0]  point_from_pipe2,
    output logic                  in_ready,
    input  logic                  dump_start,
    output logic                  dump_valid,
    input  logic                  dump_ready,
    output logic [3:0]            dump_idx,
    output logic [AccumWidth-1:0] dump_sum,
    output logic [CountWidth-1:0] dump_count,
    output logic                  dump_done,
    output logic                  overflow,
    output logic                  err_flag
);

    localparam int unsigned NumCoords = 7;
    localparam int unsigned SumW      = AccumCordWidth + 1;

    typedef enum logic {StAccum, StDump} state_e;

    state_e                state_q, state_d;
    logic [3:0]            cursor_q, cursor_d;
    logic                  done_q, done_d;
    logic                  ovf_q, ovf_d;
    logic                  err_q, err_d;
    logic [AccumWidth-1:0] sum_q [CentroidNum];
    logic [AccumWidth-1:0] sum_d [CentroidNum];
    logic [CountWidth-1:0] cnt_q [CentroidNum];
    logic [CountWidth-1:0] cnt_d [CentroidNum];

    logic                      legal;
    logic [AccumCordWidth-1:0] base;
    logic [SumW-1:0]           wide;

    assign legal = (index != 4'd0) && (index <= 4'(CentroidNum));

    always_comb begin
        state_d  = state_q;
        cursor_d = cursor_q;
        done_d   = 1'b0;
        ovf_d    = ovf_q;
        err_d    = err_q;
        base     = '0;
        wide     = '0;
        for (int c = 0; c < CentroidNum; c++) begin
            sum_d[c] = sum_q[c];
            cnt_d[c] = cnt_q[c];
        end

        unique case (state_q)
            StAccum: begin
                if (clear) begin
                    for (int c = 0; c < CentroidNum; c++) begin
                        sum_d[c] = '0;
                        cnt_d[c] = '0;
                    end
                    ovf_d = 1'b0;
                    err_d = 1'b0;
                end
                if (point_valid && !legal) begin
                    err_d = 1'b1;
                end
                for (int c = 0; c < CentroidNum; c++) begin
                    if (point_valid && legal && (index == 4'(c + 1))) begin
                        // A same-cycle clear makes this point the centroid's first member.
                        for (int k = 0; k < NumCoords; k++) begin
                            base = clear ? '0 : sum_q[c][k*AccumCordWidth +: AccumCordWidth];
                            wide = {1'b0, base}
                                 + SumW'(point_from_pipe2[k*CordWidth +: CordWidth]);
                            if (wide[AccumCordWidth]) begin
                                sum_d[c][k*AccumCordWidth +: AccumCordWidth] = '1;
                                ovf_d = 1'b1;
                            end else begin
                                sum_d[c][k*AccumCordWidth +: AccumCordWidth] =
                                    wide[AccumCordWidth-1:0];
                            end
                        end
                        if (clear) begin
                            cnt_d[c] = CountWidth'(1);
                        end else if (&cnt_q[c]) begin
                            ovf_d = 1'b1;
                        end else begin
                            cnt_d[c] = cnt_q[c] + 1'b1;
                        end
                    end
                end
                if (dump_start) begin
                    state_d  = StDump;
                    cursor_d = 4'd1;
                end
            end
            StDump: begin
                if (point_valid) begin
                    err_d = 1'b1;
                end
                if (dump_ready) begin
                    if (cursor_q == 4'(CentroidNum)) begin
                        state_d  = StAccum;
                        cursor_d = 4'd0;
                        done_d   = 1'b1;
                    end else begin
                        cursor_d = cursor_q + 4'd1;
                    end
                end
            end
            default: state_d = StAccum;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StAccum;
            cursor_q <= 4'd0;
            done_q   <= 1'b0;
            ovf_q    <= 1'b0;
            err_q    <= 1'b0;
            for (int c = 0; c < CentroidNum; c++) begin
                sum_q[c] <= '0;
                cnt_q[c] <= '0;
            end
        end else begin
            state_q  <= state_d;
            cursor_q <= cursor_d;
            done_q   <= done_d;
            ovf_q    <= ovf_d;
            err_q    <= err_d;
            for (int c = 0; c < CentroidNum; c++) begin
                sum_q[c] <= sum_d[c];
                cnt_q[c] <= cnt_d[c];
            end
        end
    end

    // Record is read straight from storage so a point taken with dump_start is included.
    always_comb begin
        dump_sum   = '0;
        dump_count = '0;
        if (state_q == StDump) begin
            for (int c = 0; c < CentroidNum; c++) begin
                if (cursor_q == 4'(c + 1)) begin
                    dump_sum   = sum_q[c];
                    dump_count = cnt_q[c];
                end
            end
        end
    end

    assign dump_idx   = cursor_q;
    assign dump_valid = (state_q == StDump);
    assign in_ready   = (state_q == StAccum);
    assign dump_done  = done_q;
    assign overflow   = ovf_q;
    assign err_flag   = err_q;

endmodule

// File: tb/tb_accumulate_block_pipe3.sv
// Randomized bench for accumulate_block_pipe3 against a plain-arithmetic centroid model.
module tb_accumulate_block_pipe3;

    logic         clk = 1'b0;
    logic         rst;
    logic         clear;
    logic         point_valid;
    logic [3:0]   index;
    logic [90:0]  point_from_pipe2;
    logic         in_ready;
    logic         dump_start;
    logic         dump_valid;
    logic         dump_ready;
    logic [3:0]   dump_idx;
    logic [153:0] dump_sum;
    logic [9:0]   dump_count;
    logic         dump_done;
    logic         overflow;
    logic         err_flag;

    accumulate_block_pipe3 dut (
        .clk              (clk),
        .rst              (rst),
        .clear            (clear),
        .point_valid      (point_valid),
        .index            (index),
        .point_from_pipe2 (point_from_pipe2),
        .in_ready         (in_ready),
        .dump_start       (dump_start),
        .dump_valid       (dump_valid),
        .dump_ready       (dump_ready),
        .dump_idx         (dump_idx),
        .dump_sum         (dump_sum),
        .dump_count       (dump_count),
        .dump_done        (dump_done),
        .overflow         (overflow),
        .err_flag         (err_flag)
    );

    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_fail = 0;

    int msum [8][7];
    int mcnt [8];
    bit movf;
    bit merr;

    task automatic check(input string tag, input logic [159:0] act, input logic [159:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < 8; c++) begin
            mcnt[c] = 0;
            for (int k = 0; k < 7; k++) msum[c][k] = 0;
        end
        movf = 0;
        merr = 0;
    endtask

    function automatic logic [153:0] exp_sum(input int c);
        logic [153:0] r;
        r = '0;
        for (int k = 0; k < 7; k++) r[22*k +: 22] = 22'(msum[c][k]);
        return r;
    endfunction

    function automatic logic [90:0] fill(input int v);
        logic [90:0] p;
        for (int k = 0; k < 7; k++) p[13*k +: 13] = 13'(v);
        return p;
    endfunction

    function automatic logic [90:0] rand_point();
        logic [90:0] p;
        for (int k = 0; k < 7; k++) p[13*k +: 13] = 13'($urandom_range(0, 8191));
        return p;
    endfunction

    // One ACCUM-state cycle; called at posedge+1.
    task automatic send(input bit pv, input int idx, input logic [90:0] pt, input bit clr);
        int c;
        point_valid      = pv;
        index            = 4'(idx);
        point_from_pipe2 = pt;
        clear            = clr;
        @(posedge clk);
        #1;
        point_valid = 0;
        clear       = 0;
        if (clr) model_reset();
        if (pv) begin
            if (idx < 1 || idx > 8) begin
                merr = 1;
            end else begin
                c = idx - 1;
                for (int k = 0; k < 7; k++) begin
                    msum[c][k] = msum[c][k] + int'(pt[13*k +: 13]);
                    if (msum[c][k] > 4194303) begin
                        msum[c][k] = 4194303;
                        movf = 1;
                    end
                end
                mcnt[c] = mcnt[c] + 1;
                if (mcnt[c] > 1023) begin
                    mcnt[c] = 1023;
                    movf = 1;
                end
            end
        end
    endtask

    // mode 0: ready held high; mode 1: ready pattern 1,0,0,... with a dropped point.
    task automatic run_dump(input int mode, input int rst_at);
        int  e;
        int  cyc;
        bit  rdy;
        e   = 1;
        cyc = 0;
        check("pre_in_ready", in_ready, 1);
        dump_start = 1;
        @(posedge clk);
        #1;
        dump_start = 0;
        while (e <= 8 && cyc < 100) begin
            if (rst_at == e) begin
                rst = 1;
                #1;
                check("rst_dump_valid", dump_valid, 0);
                check("rst_in_ready", in_ready, 1);
                check("rst_dump_idx", dump_idx, 0);
                rst        = 0;
                dump_ready = 0;
                model_reset();
                return;
            end
            rdy        = (mode == 0) || (cyc % 3 == 0);
            dump_ready = rdy;
            if (mode == 1 && cyc == 1) begin
                point_valid      = 1;
                index            = 4'($urandom_range(1, 8));
                point_from_pipe2 = rand_point();
                merr             = 1;
            end
            check("dump_valid", dump_valid, 1);
            check("dump_idx", dump_idx, e);
            check("dump_sum", dump_sum, exp_sum(e - 1));
            check("dump_count", dump_count, mcnt[e - 1]);
            check("dump_done_early", dump_done, 0);
            check("in_ready_dump", in_ready, 0);
            @(posedge clk);
            #1;
            point_valid = 0;
            if (rdy) e++;
            cyc++;
        end
        dump_ready = 0;
        check("dump_records", e, 9);
        if (mode == 0) check("dump_cycles", cyc, 8);
        check("dump_valid_end", dump_valid, 0);
        check("dump_done", dump_done, 1);
        check("in_ready_end", in_ready, 1);
        check("err_flag_dump", err_flag, merr);
        check("overflow_dump", overflow, movf);
        @(posedge clk);
        #1;
        check("dump_done_once", dump_done, 0);
    endtask

    initial begin
        rst              = 1;
        clear            = 0;
        point_valid      = 0;
        index            = 0;
        point_from_pipe2 = '0;
        dump_start       = 0;
        dump_ready       = 0;
        model_reset();
        #23;
        check("rst_in_ready", in_ready, 1);
        check("rst_dump_valid", dump_valid, 0);
        check("rst_dump_done", dump_done, 0);
        check("rst_overflow", overflow, 0);
        check("rst_err_flag", err_flag, 0);
        check("rst_dump_idx", dump_idx, 0);
        check("rst_dump_sum", dump_sum, 0);
        check("rst_dump_count", dump_count, 0);
        rst = 0;
        @(posedge clk);
        #1;

        // Three identical points, back to back, to centroid 2.
        for (int i = 0; i < 3; i++) send(1, 2, fill(5), 0);
        check("idx2_count_model", mcnt[1], 3);
        run_dump(0, 0);

        // Sum saturation, then count saturation on centroid 7.
        send(0, 0, '0, 1);
        for (int i = 0; i < 600; i++) send(1, 7, fill(8191), 0);
        check("overflow_sum", overflow, 1);
        run_dump(0, 0);
        for (int i = 0; i < 500; i++) send(1, 7, fill(0), 0);
        run_dump(0, 0);

        // Illegal indices leave storage alone and raise err_flag.
        send(0, 0, '0, 1);
        for (int i = 0; i < 10; i++) send(1, $urandom_range(1, 8), rand_point(), 0);
        send(1, 0, rand_point(), 0);
        send(1, 9, rand_point(), 0);
        check("err_flag_illegal", err_flag, 1);
        run_dump(0, 0);
        send(0, 0, '0, 1);
        check("err_flag_cleared", err_flag, 0);

        // Stalled dump with a point dropped mid-dump.
        for (int i = 0; i < 20; i++) send(1, $urandom_range(1, 8), rand_point(), 0);
        run_dump(1, 0);

        // Clear and point in the same cycle.
        send(1, 4, fill(3), 1);
        run_dump(0, 0);

        // Reset mid-dump, then an all-zero dump.
        for (int i = 0; i < 15; i++) send(1, $urandom_range(1, 8), rand_point(), 0);
        run_dump(0, 5);
        @(posedge clk);
        #1;
        run_dump(0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
